// File: rtl/rwt_sample_stream_arbiter.sv
// Packet-granular round-robin arbiter that funnels several sample streams
// into one unpack datapath through a single registered output stage.
module rwt_sample_stream_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int UWIDTH    = 1,
    parameter int SRCW      = 2
) (
    input  logic                        clk,
    input  logic                        aresetn,
    input  logic [NUM_PORTS-1:0]        port_en,
    input  logic [NUM_PORTS-1:0]        s_axi_valid,
    output logic [NUM_PORTS-1:0]        s_axi_ready,
    input  logic [4*NUM_PORTS-1:0]      s_axi_enables,
    input  logic [64*NUM_PORTS-1:0]     s_axi_data,
    input  logic [UWIDTH*NUM_PORTS-1:0] s_axi_user,
    input  logic [NUM_PORTS-1:0]        s_axi_last,
    input  logic                        m_axi_ready,
    output logic                        m_axi_valid,
    output logic [3:0]                  m_axi_enables,
    output logic [63:0]                 m_axi_data,
    output logic [UWIDTH-1:0]           m_axi_user,
    output logic                        m_axi_last,
    output logic [SRCW-1:0]             m_axi_src,
    output logic                        busy,
    output logic [SRCW-1:0]             grant
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t                state;
    logic [SRCW-1:0]       rr_ptr;
    logic [SRCW-1:0]       nxt_ptr;
    logic [NUM_PORTS-1:0]  req;
    logic                  found;
    logic [SRCW-1:0]       pick;
    logic                  lo_hit;
    logic                  hi_hit;
    logic [SRCW-1:0]       lo_pick;
    logic [SRCW-1:0]       hi_pick;

    logic                  g_valid;
    logic [3:0]            g_enables;
    logic [63:0]           g_data;
    logic [UWIDTH-1:0]     g_user;
    logic                  g_last;
    logic                  out_free;
    logic                  accept;
    logic                  keep;

    // First requester at or above rr_ptr, else wrap to the lowest requester.
    always_comb begin
        req     = s_axi_valid & port_en;
        lo_hit  = 1'b0;
        hi_hit  = 1'b0;
        lo_pick = '0;
        hi_pick = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (req[k]) begin
                lo_hit  = 1'b1;
                lo_pick = SRCW'(k);
            end
            if (req[k] && (SRCW'(k) >= rr_ptr)) begin
                hi_hit  = 1'b1;
                hi_pick = SRCW'(k);
            end
        end
        found = lo_hit;
        pick  = hi_hit ? hi_pick : lo_pick;
    end

    always_comb begin
        g_valid   = 1'b0;
        g_enables = '0;
        g_data    = '0;
        g_user    = '0;
        g_last    = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (grant == SRCW'(k)) begin
                g_valid   = s_axi_valid[k];
                g_enables = s_axi_enables[4*k +: 4];
                g_data    = s_axi_data[64*k +: 64];
                g_user    = s_axi_user[UWIDTH*k +: UWIDTH];
                g_last    = s_axi_last[k];
            end
        end
    end

    always_comb begin
        out_free    = ~m_axi_valid | m_axi_ready;
        s_axi_ready = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            s_axi_ready[k] = (state == LOCKED) && (grant == SRCW'(k)) && out_free;
        end
        accept  = (state == LOCKED) && g_valid && out_free;
        keep    = (g_enables != 4'h0) || g_last;
        nxt_ptr = (int'(grant) == NUM_PORTS - 1) ? '0 : grant + 1'b1;
    end

    assign busy = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            grant         <= '0;
            m_axi_valid   <= 1'b0;
            m_axi_enables <= '0;
            m_axi_data    <= '0;
            m_axi_user    <= '0;
            m_axi_last    <= 1'b0;
            m_axi_src     <= '0;
        end else begin
            if (m_axi_ready) begin
                m_axi_valid <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (found) begin
                        grant <= pick;
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    // Empty non-last beats are consumed but never reach the unpacker.
                    if (accept && keep) begin
                        m_axi_valid   <= 1'b1;
                        m_axi_enables <= g_enables;
                        m_axi_data    <= g_data;
                        m_axi_user    <= g_user;
                        m_axi_last    <= g_last;
                        m_axi_src     <= grant;
                    end
                    if (accept && g_last) begin
                        state  <= IDLE;
                        rr_ptr <= nxt_ptr;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rwt_sample_stream_arbiter.sv
// Bench for rwt_sample_stream_arbiter: a cycle vector table, corner-case
// sequences and a randomized run checked by a per-port packet scoreboard.
module tb_rwt_sample_stream_arbiter;
    localparam int NP = 3;
    localparam int UW = 2;
    localparam int SW = 2;

    typedef struct packed {
        logic [63:0]   data;
        logic [3:0]    en;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    typedef struct {
        logic [NP-1:0] valid;
        int            port;
        logic [63:0]   data;
        logic          last;
        logic          mready;
        logic          ev;
        logic [63:0]   edata;
        logic          elast;
        logic [SW-1:0] esrc;
        logic          ebusy;
        logic [NP-1:0] esready;
    } vec_t;

    logic                clk = 1'b0;
    logic                aresetn;
    logic [NP-1:0]       port_en;
    logic [NP-1:0]       s_axi_valid;
    logic [NP-1:0]       s_axi_ready;
    logic [4*NP-1:0]     s_axi_enables;
    logic [64*NP-1:0]    s_axi_data;
    logic [UW*NP-1:0]    s_axi_user;
    logic [NP-1:0]       s_axi_last;
    logic                m_axi_ready;
    logic                m_axi_valid;
    logic [3:0]          m_axi_enables;
    logic [63:0]         m_axi_data;
    logic [UW-1:0]       m_axi_user;
    logic                m_axi_last;
    logic [SW-1:0]       m_axi_src;
    logic                busy;
    logic [SW-1:0]       grant;

    always #5 clk = ~clk;

    rwt_sample_stream_arbiter #(
        .NUM_PORTS(NP),
        .UWIDTH   (UW),
        .SRCW     (SW)
    ) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .port_en      (port_en),
        .s_axi_valid  (s_axi_valid),
        .s_axi_ready  (s_axi_ready),
        .s_axi_enables(s_axi_enables),
        .s_axi_data   (s_axi_data),
        .s_axi_user   (s_axi_user),
        .s_axi_last   (s_axi_last),
        .m_axi_ready  (m_axi_ready),
        .m_axi_valid  (m_axi_valid),
        .m_axi_enables(m_axi_enables),
        .m_axi_data   (m_axi_data),
        .m_axi_user   (m_axi_user),
        .m_axi_last   (m_axi_last),
        .m_axi_src    (m_axi_src),
        .busy         (busy),
        .grant        (grant)
    );

    beat_t         in_q[NP][$];
    beat_t         exp_q[NP][$];
    logic [SW-1:0] src_log[$];
    int            n_pass;
    int            n_total;
    int            out_cnt;
    int            pkt_id;
    logic          in_pkt;
    logic [SW-1:0] pkt_src;
    logic [NP-1:0] en_mask;
    bit            rand_en;
    int            valid_pct;
    int            ready_pct;
    vec_t          vec[16];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic beat_t mkb(input logic [63:0] d, input logic [3:0] e, input logic l);
        beat_t b;
        b.data = d;
        b.en   = e;
        b.user = UW'(d[1:0]);
        b.last = l;
        return b;
    endfunction

    function automatic vec_t mk(input logic [NP-1:0] v, input int p, input logic [63:0] d,
                                input logic l, input logic mr, input logic ev,
                                input logic [63:0] ed, input logic el, input logic [SW-1:0] es,
                                input logic eb, input logic [NP-1:0] er);
        vec_t r;
        r.valid = v;   r.port = p;   r.data = d;    r.last = l;   r.mready = mr;
        r.ev = ev;     r.edata = ed; r.elast = el;  r.esrc = es;  r.ebusy = eb;
        r.esready = er;
        return r;
    endfunction

    task automatic drive(input int k, input logic v, input beat_t b);
        s_axi_valid[k]            = v;
        s_axi_data[64*k +: 64]    = b.data;
        s_axi_enables[4*k +: 4]   = b.en;
        s_axi_user[UW*k +: UW]    = b.user;
        s_axi_last[k]             = b.last;
    endtask

    // Reference: every beat reaches the output except empty non-last ones.
    task automatic push_beat(input int k, input beat_t b);
        in_q[k].push_back(b);
        if (b.en != 4'h0 || b.last) exp_q[k].push_back(b);
    endtask

    task automatic push_packet(input int k, input int len, input bit rnd);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = {8'(k), 24'(pkt_id), 32'($urandom)};
            b.en   = !rnd ? 4'hF : ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            b.user = UW'($urandom);
            b.last = (i == len - 1);
            push_beat(k, b);
        end
        pkt_id++;
    endtask

    task automatic check_out();
        beat_t got;
        beat_t e;
        int    s;
        got.data = m_axi_data;
        got.en   = m_axi_enables;
        got.user = m_axi_user;
        got.last = m_axi_last;
        s = int'(m_axi_src);
        out_cnt++;
        if (in_pkt) chk("pkt_interleave", m_axi_src, pkt_src);
        if (s >= NP || exp_q[s].size() == 0) begin
            n_total++;
            $display("FAIL out_unexpected: src %0d beat %0h, none expected", s, got);
        end else begin
            e = exp_q[s].pop_front();
            chk($sformatf("out_beat_src%0d", s), got, e);
        end
        in_pkt  = !m_axi_last;
        pkt_src = m_axi_src;
        if (m_axi_last) src_log.push_back(m_axi_src);
    endtask

    task automatic step();
        @(negedge clk);
        for (int k = 0; k < NP; k++) begin
            if (in_q[k].size() != 0) drive(k, $urandom_range(99) < valid_pct, in_q[k][0]);
            else drive(k, 1'b0, '0);
            port_en[k] = rand_en ? ($urandom_range(99) < 85) : en_mask[k];
        end
        m_axi_ready = $urandom_range(99) < ready_pct;
        #1;
        if (s_axi_ready != '0)
            chk("ready_rule", {$onehot(s_axi_ready), ~m_axi_valid | m_axi_ready}, 2'b11);
        if (m_axi_valid && m_axi_ready) check_out();
        for (int k = 0; k < NP; k++)
            if (s_axi_valid[k] && s_axi_ready[k]) void'(in_q[k].pop_front());
    endtask

    function automatic bit all_empty();
        for (int k = 0; k < NP; k++)
            if (in_q[k].size() != 0 || exp_q[k].size() != 0) return 1'b0;
        return !m_axi_valid;
    endfunction

    task automatic drain(input int budget, input string name);
        int n = 0;
        while (!all_empty() && n < budget) begin
            step();
            n++;
        end
        chk(name, all_empty(), 1'b1);
    endtask

    task automatic flush();
        for (int k = 0; k < NP; k++) begin
            in_q[k].delete();
            exp_q[k].delete();
        end
        in_pkt = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        localparam logic [63:0] HA = 64'h1111_1111_1111_1111;
        localparam logic [63:0] HB = 64'h2222_2222_2222_2222;
        localparam logic [63:0] HC = 64'h3333_3333_3333_3333;
        localparam logic [63:0] HD = 64'h4444_4444_4444_4444;
        localparam logic [63:0] HE = 64'h5555_5555_5555_5555;
        localparam logic [63:0] HF = 64'h6666_6666_6666_6666;
        localparam logic [63:0] HG = 64'h7777_7777_7777_7777;
        int   base;
        int   n;
        bit   cleared;
        int   alt_exp[4];
        int   en_exp[5];

        n_pass = 0; n_total = 0; out_cnt = 0; pkt_id = 0;
        in_pkt = 1'b0; pkt_src = '0; en_mask = '1; rand_en = 1'b0;
        valid_pct = 100; ready_pct = 100;
        aresetn = 1'b0; port_en = '1; s_axi_valid = '0; s_axi_data = '0;
        s_axi_enables = '0; s_axi_user = '0; s_axi_last = '0; m_axi_ready = 1'b0;

        //        valid   p  data last mr | ev edata elast src busy sready
        vec[0]  = mk(3'b001, 0, HA, 0, 1,   0, '0, 0, 0, 0, 3'b000);
        vec[1]  = mk(3'b001, 0, HA, 0, 1,   0, '0, 0, 0, 1, 3'b001);
        vec[2]  = mk(3'b001, 0, HB, 0, 1,   1, HA, 0, 0, 1, 3'b001);
        vec[3]  = mk(3'b001, 0, HC, 1, 1,   1, HB, 0, 0, 1, 3'b001);
        vec[4]  = mk(3'b000, 0, '0, 0, 1,   1, HC, 1, 0, 0, 3'b000);
        vec[5]  = mk(3'b000, 0, '0, 0, 1,   0, '0, 0, 0, 0, 3'b000);
        vec[6]  = mk(3'b010, 1, HD, 0, 1,   0, '0, 0, 0, 0, 3'b000);
        vec[7]  = mk(3'b010, 1, HD, 0, 1,   0, '0, 0, 0, 1, 3'b010);
        vec[8]  = mk(3'b010, 1, HE, 0, 1,   1, HD, 0, 1, 1, 3'b010);
        vec[9]  = mk(3'b010, 1, HF, 0, 0,   1, HE, 0, 1, 1, 3'b000);
        vec[10] = mk(3'b010, 1, HF, 0, 0,   1, HE, 0, 1, 1, 3'b000);
        vec[11] = mk(3'b010, 1, HF, 0, 1,   1, HE, 0, 1, 1, 3'b010);
        vec[12] = mk(3'b010, 1, HG, 1, 1,   1, HF, 0, 1, 1, 3'b010);
        vec[13] = mk(3'b000, 0, '0, 0, 0,   1, HG, 1, 1, 0, 3'b000);
        vec[14] = mk(3'b000, 0, '0, 0, 1,   1, HG, 1, 1, 0, 3'b000);
        vec[15] = mk(3'b000, 0, '0, 0, 1,   0, '0, 0, 0, 0, 3'b000);

        repeat (3) @(posedge clk);
        @(negedge clk);
        aresetn = 1'b1;
        #1;
        chk("rst_mvalid", m_axi_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", grant, '0);
        chk("rst_sready", s_axi_ready, '0);
        chk("rst_fields", {m_axi_data, m_axi_enables, m_axi_user, m_axi_last, m_axi_src}, '0);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            for (int k = 0; k < NP; k++) drive(k, 1'b0, '0);
            drive(vec[i].port, 1'b1, mkb(vec[i].data, 4'hF, vec[i].last));
            s_axi_valid = vec[i].valid;
            m_axi_ready = vec[i].mready;
            #1;
            chk($sformatf("v%0d_mvalid", i), m_axi_valid, vec[i].ev);
            chk($sformatf("v%0d_busy", i), busy, vec[i].ebusy);
            chk($sformatf("v%0d_sready", i), s_axi_ready, vec[i].esready);
            if (vec[i].ev) begin
                chk($sformatf("v%0d_data", i), m_axi_data, vec[i].edata);
                chk($sformatf("v%0d_last", i), m_axi_last, vec[i].elast);
                chk($sformatf("v%0d_src", i), m_axi_src, vec[i].esrc);
            end
        end

        // Empty middle beat vanishes; empty last beat still closes the packet.
        base = out_cnt;
        push_beat(1, mkb(64'hAAAA_0000_0000_0001, 4'hF, 1'b0));
        push_beat(1, mkb(64'hBBBB_0000_0000_0002, 4'h0, 1'b0));
        push_beat(1, mkb(64'hCCCC_0000_0000_0003, 4'hF, 1'b0));
        push_beat(1, mkb(64'hDDDD_0000_0000_0000, 4'h0, 1'b1));
        drain(200, "drop_drain");
        chk("drop_count", out_cnt - base, 3);

        // Two enabled ports with back-to-back packets alternate.
        en_mask = 3'b011;
        src_log.delete();
        for (int p = 0; p < 2; p++) begin
            push_packet(0, 2, 1'b0);
            push_packet(1, 2, 1'b0);
        end
        drain(200, "alt_drain");
        alt_exp = '{0, 1, 0, 1};
        chk("alt_count", src_log.size(), 4);
        for (int i = 0; i < 4 && i < src_log.size(); i++)
            chk($sformatf("alt_order%0d", i), src_log[i], alt_exp[i]);

        // port_en=101, then port0 disabled while its packet is in flight.
        en_mask = 3'b101;
        src_log.delete();
        cleared = 1'b0;
        for (int p = 0; p < 3; p++) begin
            push_packet(0, 2, 1'b0);
            push_packet(2, 2, 1'b0);
        end
        push_packet(1, 2, 1'b0);
        push_packet(1, 2, 1'b0);
        for (int c = 0; c < 60; c++) begin
            step();
            if (!cleared && in_q[0].size() == 3) begin
                en_mask[0] = 1'b0;
                cleared = 1'b1;
            end
        end
        en_exp = '{2, 0, 2, 0, 2};
        chk("en_count", src_log.size(), 5);
        for (int i = 0; i < 5 && i < src_log.size(); i++)
            chk($sformatf("en_order%0d", i), src_log[i], en_exp[i]);
        chk("en_p2_done", exp_q[2].size(), 0);
        chk("en_p0_left", in_q[0].size(), 2);
        flush();
        en_mask = '1;

        // Reset in the middle of a port1 packet with rr_ptr pointing at port1.
        push_packet(0, 1, 1'b0);
        drain(50, "pre_rst_drain");
        for (int i = 0; i < 4; i++)
            push_beat(1, mkb(64'h9000 + 64'(i), 4'hF, i == 3));
        n = 0;
        while (in_q[1].size() > 3 && n < 50) begin
            step();
            n++;
        end
        chk("rst_setup", in_q[1].size(), 3);
        @(negedge clk);
        drive(1, 1'b1, in_q[1][0]);
        m_axi_ready = 1'b1;
        aresetn = 1'b0;
        @(negedge clk);
        aresetn = 1'b1;
        s_axi_valid = '0;
        #1;
        chk("mid_rst_mvalid", m_axi_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_sready", s_axi_ready, '0);
        flush();
        src_log.delete();
        for (int k = 0; k < NP; k++) push_packet(k, 1, 1'b0);
        drain(100, "post_rst_drain");
        chk("post_rst_count", src_log.size(), 3);
        for (int i = 0; i < 3 && i < src_log.size(); i++)
            chk($sformatf("post_rst_order%0d", i), src_log[i], i);

        // Randomized traffic against the packet scoreboard.
        rand_en = 1'b1;
        valid_pct = 70;
        ready_pct = 60;
        src_log.delete();
        for (int p = 0; p < 8; p++)
            for (int k = 0; k < NP; k++)
                push_packet(k, $urandom_range(1, 5), 1'b1);
        drain(6000, "rand_drain");
        chk("rand_pkts", src_log.size(), 24);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
